// File: rtl/final_adder_digit_serial.sv
// Digit-serial final adder for a Montgomery multiplier: m = (s0_r + s1_r) mod n,
// given s0_r + s1_r < 2*n. The sum and the trial difference (sum - n) are built together, DIGIT_WIDTH bits per enabled clock.
module final_adder_digit_serial #(
  parameter int DATA_WIDTH  = 1025,
  parameter int DIGIT_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s0_r,
  input  logic [DATA_WIDTH-1:0] s1_r,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m
);

  localparam int ND = (DATA_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH;
  localparam int PW = ND * DIGIT_WIDTH;
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]          a0_sr, a1_sr, n_sr;
  logic [PW-1:0]          sum_acc, diff_acc;
  logic [PW-1:0]          sum_acc_nxt, diff_acc_nxt;
  logic [PW-1:0]          a0_in, a1_in, n_in;
  logic                   carry, borrow;
  logic [CW-1:0]          cnt;
  logic                   last_digit;
  logic [DIGIT_WIDTH:0]   sum_full;
  logic [DIGIT_WIDTH:0]   diff_full;
  logic [DIGIT_WIDTH-1:0] sum_dig, diff_dig;

  // One digit of a0 + a1 + carry; MSB of the result is the carry out.
  function automatic logic [DIGIT_WIDTH:0] add_digit(
    input logic [DIGIT_WIDTH-1:0] x,
    input logic [DIGIT_WIDTH-1:0] y,
    input logic                   c
  );
    return {1'b0, x} + {1'b0, y} + (DIGIT_WIDTH+1)'(c);
  endfunction

  // One digit of x - y - borrow; MSB of the result is the borrow out.
  function automatic logic [DIGIT_WIDTH:0] sub_digit(
    input logic [DIGIT_WIDTH-1:0] x,
    input logic [DIGIT_WIDTH-1:0] y,
    input logic                   b
  );
    return {1'b0, x} - {1'b0, y} - (DIGIT_WIDTH+1)'(b);
  endfunction

  // sum_ext >= n exactly when the sum carried out or the subtraction did not borrow.
  // Any padding bits above DATA_WIDTH are dropped by the final truncation.
  function automatic logic [DATA_WIDTH-1:0] select_result(
    input logic [PW-1:0] s,
    input logic [PW-1:0] d,
    input logic          c,
    input logic          b
  );
    logic [PW-1:0] r;
    r = (c || !b) ? d : s;
    return DATA_WIDTH'(r);
  endfunction

  assign a0_in = PW'(s0_r);
  assign a1_in = PW'(s1_r);
  assign n_in  = PW'(n);

  assign sum_full   = add_digit(a0_sr[DIGIT_WIDTH-1:0], a1_sr[DIGIT_WIDTH-1:0], carry);
  assign sum_dig    = sum_full[DIGIT_WIDTH-1:0];
  assign diff_full  = sub_digit(sum_dig, n_sr[DIGIT_WIDTH-1:0], borrow);
  assign diff_dig   = diff_full[DIGIT_WIDTH-1:0];
  assign last_digit = (cnt == CW'(ND - 1));

  // New digits enter at the MSB end, so after ND shifts digit 0 sits at bit 0.
  generate
    if (ND == 1) begin : g_single_digit
      assign sum_acc_nxt  = sum_dig;
      assign diff_acc_nxt = diff_dig;
    end else begin : g_multi_digit
      assign sum_acc_nxt  = {sum_dig,  sum_acc[PW-1:DIGIT_WIDTH]};
      assign diff_acc_nxt = {diff_dig, diff_acc[PW-1:DIGIT_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_sr    <= '0;
      a1_sr    <= '0;
      n_sr     <= '0;
      sum_acc  <= '0;
      diff_acc <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m        <= '0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a0_sr  <= a0_in;
            a1_sr  <= a1_in;
            n_sr   <= n_in;
            carry  <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          a0_sr    <= a0_sr >> DIGIT_WIDTH;
          a1_sr    <= a1_sr >> DIGIT_WIDTH;
          n_sr     <= n_sr >> DIGIT_WIDTH;
          sum_acc  <= sum_acc_nxt;
          diff_acc <= diff_acc_nxt;
          carry    <= sum_full[DIGIT_WIDTH];
          borrow   <= diff_full[DIGIT_WIDTH];
          cnt      <= cnt + CW'(1);
        end
        FINISH: begin
          m    <= select_result(sum_acc, diff_acc, carry, borrow);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
